// File: rtl/keypad_debounce_scanner.sv
// Debounced 10-key scanner: 2-flop sync, one-hot press/release debounce, one-cycle key_valid per press.
// Optional KEYPAD_MULTI_ERR_EN adds a key_err pulse when several keys appear together before acceptance.
module keypad_debounce_scanner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_raw,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_busy
`ifdef KEYPAD_MULTI_ERR_EN
  ,
  output logic       key_err
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [7:0] DB_MAX  = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] DB_LAST = DB_MAX - 8'd1;

  logic [9:0] sync_a, sync_s;
  state_t     state, state_nx;
  logic [9:0] latched, latched_nx;
  logic [7:0] cnt, cnt_nx;
  logic       valid_nx;
  logic [3:0] code_nx;
  logic       cls_none, cls_single, cls_multi;

  function automatic logic [3:0] onehot_to_idx(input logic [9:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign cls_none   = (sync_s == 10'd0);
  assign cls_single = !cls_none && ((sync_s & (sync_s - 10'd1)) == 10'd0);
  assign cls_multi  = !cls_none && !cls_single;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a    <= 10'd0;
      sync_s    <= 10'd0;
      state     <= IDLE;
      latched   <= 10'd0;
      cnt       <= 8'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      sync_a    <= key_raw;
      sync_s    <= sync_a;
      state     <= state_nx;
      latched   <= latched_nx;
      cnt       <= cnt_nx;
      key_valid <= valid_nx;
      key_code  <= code_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx   = state;
    latched_nx = latched;
    cnt_nx     = cnt;
    valid_nx   = 1'b0;
    code_nx    = key_code;
    unique case (state)
      IDLE: begin
        if (cls_single) begin
          latched_nx = sync_s;
          cnt_nx     = 8'd1;
          state_nx   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sync_s == latched) begin
          cnt_nx = (cnt < DB_MAX) ? cnt + 8'd1 : DB_MAX;
          if (cnt == DB_LAST) begin
            state_nx = HELD;
            valid_nx = 1'b1;
            code_nx  = onehot_to_idx(latched);
          end
        end else begin
          cnt_nx   = 8'd0;
          state_nx = IDLE;
        end
      end
      HELD: begin
        // Extra keys while held are deliberately ignored; only all-zero starts a release.
        if (cls_none) begin
          cnt_nx   = 8'd1;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (cls_none) begin
          if (cnt + 8'd1 >= DB_MAX) begin
            cnt_nx   = 8'd0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end else begin
          cnt_nx   = 8'd0;
          state_nx = HELD;
        end
      end
      default: begin
        cnt_nx   = 8'd0;
        state_nx = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    key_busy = (state != IDLE);
  end

`ifdef KEYPAD_MULTI_ERR_EN
  logic prev_multi;
  logic err_nx;

  always_comb begin
    err_nx = cls_multi && !prev_multi && ((state == IDLE) || (state == DEBOUNCE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_multi <= 1'b0;
      key_err    <= 1'b0;
    end else begin
      prev_multi <= cls_multi;
      key_err    <= err_nx;
    end
  end
`endif

endmodule

// File: doc/keypad_debounce_scanner.md
KEYPAD_DEBOUNCE_SCANNER -- requirements
Module: keypad_debounce_scanner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples required to accept a press or a release (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port key_raw, input, 10, asynchronous raw keypad lines; bit i high = key for digit i pressed.
REQ-005 SHALL have port key_valid, output, 1, one-cycle pulse marking an accepted press.
REQ-006 SHALL have port key_code, output, 4, binary digit 0..9 of the last accepted press, in the same format the input encoder produces on out[3:0].
REQ-007 SHALL have port key_busy, output, 1, high whenever the FSM is not in IDLE.
REQ-008 SHALL have port key_err, output, 1, present only when KEYPAD_MULTI_ERR_EN is defined.

Function
REQ-009 SHALL pass key_raw through a 2-flop synchronizer per bit; all further logic uses only the synchronized vector S.
REQ-010 SHALL classify S each cycle as NONE (all zero), SINGLE (exactly one bit set), or MULTI (two or more bits set).
REQ-011 SHALL implement FSM states IDLE, DEBOUNCE, HELD, RELEASE with an 8-bit stability counter.
REQ-012 IDLE: on SINGLE, SHALL latch the one-hot S, set counter=1, and go to DEBOUNCE; on NONE or MULTI, SHALL stay in IDLE.
REQ-013 DEBOUNCE: while S equals the latched one-hot, SHALL increment the counter; at the edge where the counter equals DEBOUNCE_CYCLES-1 with S still matching, SHALL go to HELD, register key_valid=1 and load key_code with the latched index.
REQ-014 DEBOUNCE: if S differs from the latched value (NONE, MULTI, or another single key), SHALL go to IDLE with counter=0 and no pulse.
REQ-015 Latency: for a clean press first sampled at edge 0, key_valid SHALL be high during the cycle after edge DEBOUNCE_CYCLES+1; for example, edge 5 for the default.
REQ-016 key_valid SHALL be high for exactly one cycle per accepted press, with no auto-repeat while the key is held.
REQ-017 HELD: on NONE, SHALL go to RELEASE with counter=1; any non-zero S, including added keys, SHALL keep the FSM in HELD and be ignored.
REQ-018 RELEASE: on NONE, SHALL increment the counter and go to IDLE when the counter would reach DEBOUNCE_CYCLES; any non-zero S SHALL return the FSM to HELD with counter=0 and no new pulse.
REQ-019 key_code SHALL change only in the cycle key_valid is asserted and SHALL hold its value otherwise.
REQ-020 The counter SHALL never wrap; it saturates at DEBOUNCE_CYCLES.

Reset
REQ-021 While rst is high at a clock edge, SHALL clear the synchronizer flops, latched key and counter to 0, force state to IDLE, and drive key_valid=0, key_code=0000, key_busy=0, and key_err=0.
REQ-022 Reset SHALL take priority over all FSM activity; a press that is in progress is discarded.
REQ-023 A key still held after rst deasserts SHALL be treated as a new press and fully re-debounced.

Configuration
REQ-024 With KEYPAD_MULTI_ERR_EN defined, SHALL pulse key_err for one cycle when the classification enters MULTI from a non-MULTI class while the FSM is in IDLE or DEBOUNCE.
REQ-025 With KEYPAD_MULTI_ERR_EN defined, SHALL assert no key_err in HELD or RELEASE.
REQ-026 Without KEYPAD_MULTI_ERR_EN, the key_err port and its logic SHALL be absent; MULTI handling per REQ-012/014 is unchanged.

Verification
REQ-027 Default params: rst for 2 cycles, then key_raw[2]=1 held 10 cycles and released -> a single key_valid at edge 5 with key_code=0010; key_busy returns to 0 four cycles after S goes to zero.
REQ-028 Bounce: key_raw[7] toggled 1,0,1,0 per cycle, then held 8 cycles -> no pulse during the toggling, then exactly one key_valid with key_code=0111.
REQ-029 Multi: key_raw[1] and key_raw[9] rise together and are held 10 cycles -> no key_valid; with KEYPAD_MULTI_ERR_EN, exactly one key_err pulse.
REQ-030 Held plus extra: key_raw[3] is accepted, then key_raw[5] is added while held -> no second pulse, and key_code stays 0011 until full release.
REQ-031 Release glitch: after key 4 is accepted, release for 2 cycles, re-press for 1 cycle, then release -> no new pulse, and IDLE is reached only after 4 consecutive zero samples.
REQ-032 Mid-press reset: rst pulsed at debounce count 2 while key_raw[8] stays high -> no pulse during reset, then one key_valid with code 1000 at edge 5 after rst deasserts.
